// File: rtl/ppi_sync_hs.sv
// ppi_sync_hs: clocked 8255-style parallel interface with NUM_PORTS strobed/handshake
// data ports, bit-addressable port C and a control/status register.
module ppi_sync_hs #(
  parameter int DATA_W    = 8,
  parameter int NUM_PORTS = 2,
  parameter int AW        = $clog2(NUM_PORTS + 2)
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_cs_n,
  input  logic                          i_rd_n,
  input  logic                          i_wr_n,
  input  logic [AW-1:0]                 i_a,
  input  logic [DATA_W-1:0]             i_d,
  output logic [DATA_W-1:0]             o_d,
  output logic                          o_d_oe,
  input  logic [NUM_PORTS*DATA_W-1:0]   i_p,
  output logic [NUM_PORTS*DATA_W-1:0]   o_p,
  output logic [NUM_PORTS-1:0]          o_p_oe,
  input  logic [DATA_W-1:0]             i_pc,
  output logic [DATA_W-1:0]             o_pc,
  output logic                          o_pc_oe,
  input  logic [NUM_PORTS-1:0]          i_stb_n,
  input  logic [NUM_PORTS-1:0]          i_ack_n,
  output logic [NUM_PORTS-1:0]          o_ibf,
  output logic [NUM_PORTS-1:0]          o_obf_n,
  output logic [NUM_PORTS-1:0]          o_intr
);
  localparam int N  = NUM_PORTS;
  localparam int IW = $clog2(DATA_W);

  logic [N-1:0]        r_dir, r_mode, r_inte, r_ibf, r_obf_n, r_intr, r_ovr;
  logic                r_pc_dir;
  logic [N*DATA_W-1:0] r_lat, r_p_s1, r_p_s2;
  logic [DATA_W-1:0]   r_pc, r_pc_s1, r_pc_s2;
  logic [N-1:0]        r_stb_s1, r_stb_s2, r_stb_s3, r_ack_s1, r_ack_s2, r_ack_s3;
  logic                r_wr_q, r_rd_q, r_wpend, r_rpend;
  logic [AW-1:0]       r_waddr, r_raddr;

  logic                w_wr, w_rd1, w_wend, w_rend, w_mset, w_bsr;
  logic [IW-1:0]       w_bidx;
  logic [N-1:0]        w_stb_fall, w_stb_rise, w_ack_fall, w_ack_rise, w_m1i, w_m1o;
  logic [N-1:0]        w_wsel, w_rsel, w_wend_k, w_rend_k;
  logic [DATA_W-1:0]   w_status;

  assign w_wr       = ~i_cs_n & ~i_wr_n & r_wr_q;
  assign w_rd1      = ~i_cs_n & ~i_rd_n & r_rd_q;
  assign w_wend     = r_wpend & i_wr_n;
  assign w_rend     = r_rpend & i_rd_n;
  assign w_mset     = w_wr & (i_a == AW'(N + 1)) & i_d[DATA_W-1];
  assign w_bsr      = w_wr & (i_a == AW'(N + 1)) & ~i_d[DATA_W-1];
  assign w_bidx     = i_d[IW:1];
  assign w_stb_fall = ~r_stb_s2 & r_stb_s3;
  assign w_stb_rise = r_stb_s2 & ~r_stb_s3;
  assign w_ack_fall = ~r_ack_s2 & r_ack_s3;
  assign w_ack_rise = r_ack_s2 & ~r_ack_s3;
  assign w_m1i      = r_mode & r_dir;
  assign w_m1o      = r_mode & ~r_dir;

  assign o_p     = r_lat;
  assign o_p_oe  = ~r_dir;
  assign o_pc    = r_pc;
  assign o_pc_oe = ~r_pc_dir;
  assign o_ibf   = r_ibf;
  assign o_obf_n = r_obf_n;
  assign o_intr  = r_intr;
  assign o_d_oe  = i_rst_n & ~i_cs_n & ~i_rd_n;

  generate
    if (4 * N <= DATA_W) begin : g_ovr
      assign w_status = DATA_W'({r_ovr, r_intr, ~r_obf_n, r_ibf});
    end else begin : g_no_ovr
      assign w_status = DATA_W'({r_intr, ~r_obf_n, r_ibf});
    end
  endgenerate

  always_comb begin
    w_wsel   = '0;
    w_rsel   = '0;
    w_wend_k = '0;
    w_rend_k = '0;
    for (int k = 0; k < N; k++) begin
      w_wsel[k]   = w_wr & (i_a == AW'(k));
      w_rsel[k]   = w_rd1 & (i_a == AW'(k));
      w_wend_k[k] = w_wend & (r_waddr == AW'(k));
      w_rend_k[k] = w_rend & (r_raddr == AW'(k));
    end
  end

  always_comb begin
    o_d = '0;
    if (i_a == AW'(N + 1)) o_d = w_status;
    else if (i_a == AW'(N)) o_d = r_pc_dir ? r_pc_s2 : r_pc;
    for (int k = 0; k < N; k++)
      if (i_a == AW'(k))
        o_d = (r_dir[k] & ~r_mode[k]) ? r_p_s2[k*DATA_W +: DATA_W] : r_lat[k*DATA_W +: DATA_W];
  end

  // Pin synchronisers; the third handshake stage holds the previous value for edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_p_s1   <= '0;
      r_p_s2   <= '0;
      r_pc_s1  <= '0;
      r_pc_s2  <= '0;
      r_stb_s1 <= '1;
      r_stb_s2 <= '1;
      r_stb_s3 <= '1;
      r_ack_s1 <= '1;
      r_ack_s2 <= '1;
      r_ack_s3 <= '1;
    end else begin
      r_p_s1   <= i_p;
      r_p_s2   <= r_p_s1;
      r_pc_s1  <= i_pc;
      r_pc_s2  <= r_pc_s1;
      r_stb_s1 <= i_stb_n;
      r_stb_s2 <= r_stb_s1;
      r_stb_s3 <= r_stb_s2;
      r_ack_s1 <= i_ack_n;
      r_ack_s2 <= r_ack_s1;
      r_ack_s3 <= r_ack_s2;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_q  <= 1'b1;
      r_rd_q  <= 1'b1;
      r_wpend <= 1'b0;
      r_rpend <= 1'b0;
      r_waddr <= '0;
      r_raddr <= '0;
    end else begin
      r_wr_q <= i_wr_n;
      r_rd_q <= i_rd_n;
      if (w_wr) begin
        r_wpend <= 1'b1;
        r_waddr <= i_a;
      end else if (i_wr_n || i_cs_n) r_wpend <= 1'b0;
      if (w_rd1) begin
        r_rpend <= 1'b1;
        r_raddr <= i_a;
      end else if (i_rd_n || i_cs_n) r_rpend <= 1'b0;
    end
  end

  // Within each port clears are written before sets so a same-cycle set wins; mode set overrides all.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dir    <= '1;
      r_mode   <= '0;
      r_inte   <= '0;
      r_pc_dir <= 1'b1;
      r_lat    <= '0;
      r_pc     <= '0;
      r_ibf    <= '0;
      r_obf_n  <= '1;
      r_intr   <= '0;
      r_ovr    <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (w_wsel[k] && !w_m1i[k]) r_lat[k*DATA_W +: DATA_W] <= i_d;
        if (w_m1o[k]) begin
          if (w_wsel[k]) r_intr[k] <= 1'b0;
          if (w_ack_fall[k]) r_obf_n[k] <= 1'b1;
          if (w_wend_k[k]) r_obf_n[k] <= 1'b0;
          if (w_ack_rise[k] && r_inte[k]) r_intr[k] <= 1'b1;
        end
        if (w_m1i[k]) begin
          if (w_rsel[k]) r_intr[k] <= 1'b0;
          if (w_rend_k[k]) r_ibf[k] <= 1'b0;
          if (w_stb_fall[k]) begin
            if (r_ibf[k] && !w_rend_k[k]) r_ovr[k] <= 1'b1;
            else begin
              r_lat[k*DATA_W +: DATA_W] <= i_p[k*DATA_W +: DATA_W];
              r_ibf[k] <= 1'b1;
            end
          end
          if (w_stb_rise[k] && r_ibf[k] && r_inte[k]) r_intr[k] <= 1'b1;
        end
      end
      if (w_wr && i_a == AW'(N)) r_pc <= i_d;
      if (w_bsr && {1'b0, w_bidx} < (IW + 1)'(DATA_W)) r_pc[w_bidx] <= i_d[0];
      if (w_mset) begin
        r_dir    <= i_d[N-1:0];
        r_mode   <= i_d[2*N-1:N];
        r_inte   <= i_d[3*N-1:2*N];
        r_pc_dir <= i_d[3*N];
        r_lat    <= '0;
        r_pc     <= '0;
        r_ibf    <= '0;
        r_obf_n  <= '1;
        r_intr   <= '0;
        r_ovr    <= '0;
      end
    end
  end
endmodule

// File: tb/tb_ppi_sync_hs.sv
// tb_ppi_sync_hs: scoreboard bench for ppi_sync_hs; reads queue expected data, a monitor checks D_OUT.
module tb_ppi_sync_hs;
  localparam int W = 8, N = 2, AW = 2;

  logic          clk = 0, rst_n = 0, cs_n = 1, rd_n = 1, wr_n = 1;
  logic [AW-1:0] a = '0;
  logic [W-1:0]  d = '0, d_out, pc_in = '0, pc_out;
  logic          d_oe, pc_oe;
  logic [N*W-1:0] p_in = '0, p_out;
  logic [N-1:0]  p_oe, stb_n = '1, ack_n = '1, ibf, obf_n, intr;

  int errs = 0, checks = 0;
  logic [7:0] exp_q[$];

  logic [1:0] m_dir;
  logic       m_pcdir;
  logic [7:0] m_lat[2];
  logic [7:0] m_pc;

  ppi_sync_hs #(.DATA_W(W), .NUM_PORTS(N), .AW(AW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cs_n(cs_n), .i_rd_n(rd_n), .i_wr_n(wr_n),
    .i_a(a), .i_d(d), .o_d(d_out), .o_d_oe(d_oe),
    .i_p(p_in), .o_p(p_out), .o_p_oe(p_oe),
    .i_pc(pc_in), .o_pc(pc_out), .o_pc_oe(pc_oe),
    .i_stb_n(stb_n), .i_ack_n(ack_n), .o_ibf(ibf), .o_obf_n(obf_n), .o_intr(intr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (d_oe) begin
      if (exp_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL read: unexpected D_OUT %0h with no expectation", d_out);
      end else chk("read", d_out, exp_q.pop_front());
    end

  task automatic wr_bus(input logic [1:0] ad, input logic [7:0] v);
    @(posedge clk); #1 cs_n = 0; wr_n = 0; a = ad; d = v;
    @(posedge clk); #1 wr_n = 1;
    @(posedge clk); #1 cs_n = 1;
  endtask

  task automatic rd_bus(input logic [1:0] ad, input logic [7:0] e);
    @(posedge clk); #1 cs_n = 0; rd_n = 0; a = ad; exp_q.push_back(e);
    @(posedge clk); #1 rd_n = 1;
    @(posedge clk); #1 cs_n = 1;
  endtask

  task automatic mset(input logic [7:0] v);
    wr_bus(2'd3, v);
    m_dir = v[1:0]; m_pcdir = v[6]; m_lat[0] = 0; m_lat[1] = 0; m_pc = 0;
  endtask

  task automatic chk_pins();
    chk("p_oe", p_oe, {~m_dir});
    chk("p_out", p_out, {m_lat[1], m_lat[0]});
    chk("pc_out", pc_out, m_pc);
    chk("pc_oe", pc_oe, !m_pcdir);
  endtask

  task automatic pulse_stb(input logic [7:0] v);
    p_in[7:0] = v;
    @(posedge clk); #1 stb_n[0] = 0;
    repeat (4) @(posedge clk); #1 stb_n[0] = 1;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    int op, k;
    logic [7:0] v;
    repeat (3) @(posedge clk); #1;
    chk("rst_ibf", ibf, 0); chk("rst_obf_n", obf_n, 2'b11); chk("rst_intr", intr, 0);
    chk("rst_p_oe", p_oe, 0); chk("rst_p_out", p_out, 0); chk("rst_pc_oe", pc_oe, 0);
    chk("rst_pc_out", pc_out, 0); chk("rst_d_oe", d_oe, 0);
    @(posedge clk); #1 rst_n = 1;

    // Mode 0: all inputs, then port0 output
    mset(8'hC3);
    p_in[7:0] = 8'h5A;
    repeat (3) @(posedge clk);
    rd_bus(0, 8'h5A);
    chk("m0_in_p_oe", p_oe, 0);
    rd_bus(3, 8'h00);
    mset(8'h82);
    wr_bus(0, 8'h3C); m_lat[0] = 8'h3C;
    chk("m0_out_p", p_out[7:0], 8'h3C); chk("m0_out_oe", p_oe[0], 1);
    rd_bus(0, 8'h3C);

    // BSR
    wr_bus(3, 8'h0F); chk("bsr_set7", pc_out, 8'h80);
    wr_bus(3, 8'h03); chk("bsr_set1", pc_out, 8'h82);
    wr_bus(3, 8'h00); chk("bsr_clr0", pc_out, 8'h82);
    mset(8'h82); chk("mset_clr_pc", pc_out, 8'h00);

    // Randomized Mode 0 traffic against the model
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 7); k = $urandom_range(0, 1); v = 8'($urandom);
      case (op)
        0: mset((v & 8'h73) | 8'h80);
        1: begin wr_bus(2'(k), v); m_lat[k] = v; end
        2: rd_bus(2'(k), m_dir[k] ? p_in[k*8 +: 8] : m_lat[k]);
        3: begin v[7] = 0; wr_bus(3, v); m_pc[v[3:1]] = v[0]; end
        4: rd_bus(2, m_pcdir ? pc_in : m_pc);
        5: begin p_in = 16'($urandom); pc_in = 8'($urandom); repeat (3) @(posedge clk); end
        6: rd_bus(3, 8'h00);
        default: begin wr_bus(2, v); m_pc = v; end
      endcase
      chk_pins();
    end

    // Mode 1 input on port0
    mset(8'hB5);
    p_in[7:0] = 8'hA7;
    @(posedge clk); #1 stb_n[0] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) chk("ibf_early", ibf[0], 0);
    @(negedge clk) chk("ibf_set", ibf[0], 1);
    chk("intr_before_rise", intr[0], 0);
    @(posedge clk); #1 stb_n[0] = 1;
    repeat (4) @(posedge clk);
    @(negedge clk) chk("intr_after_rise", intr[0], 1);
    rd_bus(0, 8'hA7);
    chk("intr_rd_clr", intr[0], 0); chk("ibf_rd_clr", ibf[0], 0);
    pulse_stb(8'h3B);
    pulse_stb(8'hEE);
    rd_bus(3, 8'h51);
    rd_bus(0, 8'h3B);
    rd_bus(3, 8'h40);

    // Mode 1 output on port1
    mset(8'hA8);
    wr_bus(1, 8'h99);
    chk("obf_wr", obf_n[1], 0); chk("p1_out", p_out[15:8], 8'h99); chk("m1o_oe", p_oe, 2'b11);
    @(posedge clk); #1 ack_n[1] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) chk("obf_hold", obf_n[1], 0);
    @(negedge clk) chk("obf_ack", obf_n[1], 1);
    @(posedge clk); #1 ack_n[1] = 1;
    repeat (4) @(posedge clk);
    @(negedge clk) chk("intr_ack", intr[1], 1);
    rd_bus(3, 8'h20);
    wr_bus(1, 8'h11);
    chk("intr_wr_clr", intr[1], 0); chk("obf_wr2", obf_n[1], 0);
    rd_bus(3, 8'h08);

    // Asynchronous reset mid-handshake
    mset(8'hBD);
    pulse_stb(8'h55);
    wr_bus(1, 8'h77);
    wr_bus(3, 8'h0F);
    chk("pre_rst_ibf", ibf, 2'b01); chk("pre_rst_obf_n", obf_n, 2'b01);
    @(posedge clk); #3 rst_n = 0;
    #1;
    chk("arst_ibf", ibf, 0); chk("arst_obf_n", obf_n, 2'b11); chk("arst_intr", intr, 0);
    chk("arst_p_oe", p_oe, 0); chk("arst_p_out", p_out, 0);
    chk("arst_pc_out", pc_out, 0); chk("arst_pc_oe", pc_oe, 0);
    @(posedge clk); #1 rst_n = 1;
    repeat (3) @(posedge clk);
    chk("sb_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
